// File: rtl/mem_access_stage.sv
// LEGv8 memory stage: forwards ALU results or runs a req/ack data-memory access,
// stalling upstream while the access is outstanding and emitting registered writeback fields.
module mem_access_stage #(
  parameter int WORD        = 64,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [WORD-1:0] alu_result,
  input  logic [WORD-1:0] write_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic [4:0]      rd,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [WORD-1:0] dmem_addr,
  output logic [WORD-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [WORD-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [WORD-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic            fault
);

  typedef enum logic {IDLE, ACCESS} state_t;

  // The counter holds completed waiting cycles, so the last permitted ACCESS
  // cycle is the one where it reads ACK_TIMEOUT-1.
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        cap_load;
  logic [4:0]  cap_rd;
  logic        cap_reg_write;

  logic mem_op, aligned, timeout_hit, rd_writable;
  logic issue, retire_alu, fault_misalign, retire_ack, retire_timeout;

  assign mem_op      = ex_valid & (mem_read | mem_write);
  assign aligned     = (alu_result[2:0] == 3'b000);
  assign timeout_hit = (cnt == TO_LAST);
  assign rd_writable = (rd != 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    mem_stall      = 1'b0;
    issue          = 1'b0;
    retire_alu     = 1'b0;
    fault_misalign = 1'b0;
    retire_ack     = 1'b0;
    retire_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            issue     = 1'b1;
            mem_stall = 1'b1;
            state_nxt = ACCESS;
          end else begin
            fault_misalign = 1'b1;
          end
        end else if (ex_valid) begin
          retire_alu = 1'b1;
        end
      end
      ACCESS: begin
        // Ack takes priority over an expiring timeout in the same cycle.
        if (dmem_ack) begin
          retire_ack = 1'b1;
          state_nxt  = IDLE;
        end else if (timeout_hit) begin
          retire_timeout = 1'b1;
          state_nxt      = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request side and captured instruction context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      cap_load      <= 1'b0;
      cap_rd        <= '0;
      cap_reg_write <= 1'b0;
      cnt           <= '0;
    end else begin
      if (issue) begin
        dmem_req      <= 1'b1;
        dmem_we       <= mem_write;
        dmem_addr     <= alu_result;
        dmem_wdata    <= write_data;
        cap_load      <= ~mem_write;
        cap_rd        <= rd;
        cap_reg_write <= reg_write & rd_writable;
        cnt           <= '0;
      end else if (retire_ack || retire_timeout) begin
        dmem_req <= 1'b0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  // Writeback side: wb_valid and fault pulse, the data fields hold between retirements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      fault        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      if (retire_alu) begin
        wb_valid     <= 1'b1;
        wb_data      <= alu_result;
        wb_rd        <= rd;
        wb_reg_write <= reg_write & rd_writable;
      end else if (fault_misalign) begin
        wb_valid     <= 1'b1;
        fault        <= 1'b1;
        wb_data      <= alu_result;
        wb_rd        <= rd;
        wb_reg_write <= 1'b0;
      end else if (retire_ack) begin
        wb_valid     <= 1'b1;
        wb_data      <= cap_load ? dmem_rdata : dmem_addr;
        wb_rd        <= cap_rd;
        wb_reg_write <= cap_load & cap_reg_write;
      end else if (retire_timeout) begin
        wb_valid     <= 1'b1;
        fault        <= 1'b1;
        wb_data      <= dmem_addr;
        wb_rd        <= cap_rd;
        wb_reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage: the driver plays both the EX stage
// and the data memory, and pushes the expected writeback of each instruction.
module tb_mem_access_stage;
  localparam int WORD = 64;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, mem_read, mem_write, reg_write;
  logic [WORD-1:0] alu_result, write_data;
  logic [4:0]      rd;
  logic            mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [WORD-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic            wb_valid, wb_reg_write, fault;
  logic [WORD-1:0] wb_data;
  logic [4:0]      wb_rd;

  mem_access_stage #(.WORD(WORD), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_result(alu_result),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .rd(rd), .mem_stall(mem_stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic            flt;
    logic [WORD-1:0] data;
    logic [4:0]      rd;
    logic            rw;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic flt, input logic [WORD-1:0] data, input logic [4:0] r, input logic rw);
    exp_t e;
    e.cyc = cyc + 1; e.flt = flt; e.data = data; e.rd = r; e.rw = rw;
    q.push_back(e);
  endtask

  // Monitor: every retirement the DUT presents is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || fault)) begin
      exp_t e;
      compared++;
      if (!wb_valid || q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_output: wb_valid=%0b fault=%0b queued=%0d at cycle %0d",
                 wb_valid, fault, q.size(), cyc);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || fault != e.flt || wb_reg_write != e.rw ||
            (!e.flt && (wb_data != e.data || wb_rd != e.rd))) begin
          mismatched++;
          $display("FAIL retire: got cyc=%0d fault=%0b rw=%0b data=0x%0h rd=%0d expected cyc=%0d fault=%0b rw=%0b data=0x%0h rd=%0d",
                   cyc, fault, wb_reg_write, wb_data, wb_rd, e.cyc, e.flt, e.rw, e.data, e.rd);
        end
      end
    end
  end

  task automatic idle_inputs();
    ex_valid = 0; mem_read = 0; mem_write = 0; reg_write = 0; rd = 0;
    alu_result = '0; write_data = '0; dmem_ack = 0; dmem_rdata = '0;
  endtask

  // One instruction presented now; k = ACCESS cycle in which memory acks (k > TO: never).
  task automatic do_op(input logic mr, input logic mw, input logic [WORD-1:0] addr,
                       input logic [WORD-1:0] wd, input logic [4:0] r, input logic rw,
                       input int k, input logic [WORD-1:0] rdata);
    logic is_store, wr_ok;
    is_store = mw;
    wr_ok = rw && (r != 5'd31);
    ex_valid = 1; mem_read = mr; mem_write = mw; alu_result = addr;
    write_data = wd; rd = r; reg_write = rw; dmem_ack = 0;
    #1;
    if (!(mr || mw)) begin
      check("alu_stall", 64'(mem_stall), 64'd0);
      push(1'b0, addr, r, wr_ok);
      tick();
    end else if (addr[2:0] != 3'b000) begin
      check("misalign_stall", 64'(mem_stall), 64'd0);
      push(1'b1, addr, r, 1'b0);
      tick();
      check("misalign_no_req", 64'(dmem_req), 64'd0);
    end else begin
      check("issue_stall", 64'(mem_stall), 64'd1);
      tick();
      check("req", 64'(dmem_req), 64'd1);
      check("addr", dmem_addr, addr);
      check("we", 64'(dmem_we), 64'(is_store));
      if (is_store) check("wdata", dmem_wdata, wd);
      for (int i = 1; i <= TO; i++) begin
        if (i == k) begin
          dmem_ack = 1; dmem_rdata = rdata;
          #1;
          check("ack_stall", 64'(mem_stall), 64'd0);
          push(1'b0, is_store ? addr : rdata, r, !is_store && wr_ok);
          tick();
          dmem_ack = 0;
          break;
        end else if (i == TO) begin
          #1;
          check("timeout_stall", 64'(mem_stall), 64'd0);
          push(1'b1, addr, r, 1'b0);
          tick();
        end else begin
          check("wait_stall", 64'(mem_stall), 64'd1);
          check("wait_req", 64'(dmem_req), 64'd1);
          tick();
        end
      end
      check("req_dropped", 64'(dmem_req), 64'd0);
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WORD-1:0] a, wd, rdv;
    logic mr, mw;
    logic [4:0] r;
    int kind;

    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_we", 64'(dmem_we), 64'd0);
    check("rst_addr", dmem_addr, 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_stall", 64'(mem_stall), 64'd0);
    rst_n = 1;
    tick();

    do_op(0, 0, 64'h1234, 64'h0, 5'd5, 1, 0, '0);
    tick();
    do_op(1, 0, 64'h40, 64'h0, 5'd2, 1, 2, 64'hDEADBEEF);
    do_op(0, 1, 64'h80, 64'h55, 5'd7, 1, 1, 64'h0);
    do_op(1, 0, 64'h44, 64'h0, 5'd3, 1, 1, 64'h0);
    do_op(1, 0, 64'h100, 64'h0, 5'd4, 1, TO + 1, 64'h0);
    do_op(1, 0, 64'h108, 64'h0, 5'd6, 1, TO, 64'hCAFE);
    do_op(1, 0, 64'h110, 64'h0, 5'd31, 1, 1, 64'h77);
    do_op(0, 0, 64'h99, 64'h0, 5'd31, 1, 0, '0);
    do_op(1, 1, 64'h118, 64'hABCD, 5'd8, 1, 3, 64'h11);

    // Reset in the middle of an outstanding access, then stray acks in IDLE.
    ex_valid = 1; mem_read = 1; alu_result = 64'h200; rd = 5'd9; reg_write = 1;
    tick();
    check("midrst_req_before", 64'(dmem_req), 64'd1);
    idle_inputs();
    rst_n = 0;
    #1;
    check("midrst_req", 64'(dmem_req), 64'd0);
    check("midrst_stall", 64'(mem_stall), 64'd0);
    check("midrst_wb_valid", 64'(wb_valid), 64'd0);
    tick();
    rst_n = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      dmem_ack = 1; dmem_rdata = 64'h5A5A;
      tick();
      check("stray_ack_wb", 64'(wb_valid), 64'd0);
      check("stray_ack_req", 64'(dmem_req), 64'd0);
    end
    dmem_ack = 0;

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      r  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      a  = {$urandom(), $urandom()};
      wd = {$urandom(), $urandom()};
      rdv = {$urandom(), $urandom()};
      if (kind < 2) begin
        mem_read = 1'($urandom()); mem_write = 1'($urandom());
        dmem_ack = 1'($urandom()); alu_result = a;
        tick();
        idle_inputs();
      end else if (kind < 5) begin
        do_op(0, 0, a, wd, r, 1'($urandom()), 0, '0);
      end else begin
        mr = 1'($urandom()); mw = 1'($urandom());
        if (!mr && !mw) mr = 1;
        if ($urandom_range(0, 4) != 0) a[2:0] = 3'b000;
        else a[2:0] = 3'($urandom_range(1, 7));
        do_op(mr, mw, a, wd, r, 1'($urandom()), $urandom_range(1, TO + 1), rdv);
      end
    end

    repeat (3) tick();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
